// File: rtl/xstep_seq_pkg.sv
// Register offsets, CTRL/STATUS bit positions and FSM encoding for the step sequencer.
// Pure definitions: no logic, no latency.
// Shared with controller firmware, so values must stay stable.
package xstep_seq_pkg;

    localparam int SEQ_CTRL   = 0;
    localparam int SEQ_TEMPO  = 1;
    localparam int SEQ_STATUS = 2;
    localparam int SEQ_MASK   = 3;
    localparam int SEQ_FREQ0  = 4;

    localparam int CTRL_RUN  = 0;
    localparam int CTRL_LOOP = 1;
    localparam int CTRL_CLR  = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_STEP = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } seq_state_t;

endpackage

// File: rtl/xstep_seq_tone.sv
// Square-wave tone generator: toggles snd_out every half_period clocks while enabled.
// Latency: first toggle half_period cycles after restart or enable.
// No backpressure; restart or disable forces the counter and output to 0.
module xstep_tone #(
    parameter int FREQ_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              restart,
    input  logic [FREQ_W-1:0] half_period,
    output logic              snd_out
);

    logic [FREQ_W-1:0] cnt_q;
    logic              wrap;

    // >= rather than == so a shorter half_period written mid-count still wraps
    assign wrap = (cnt_q >= (half_period - FREQ_W'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            snd_out <= 1'b0;
        end else if (restart || !en) begin
            cnt_q   <= '0;
            snd_out <= 1'b0;
        end else if (wrap) begin
            cnt_q   <= '0;
            snd_out <= ~snd_out;
        end else begin
            cnt_q   <= cnt_q + FREQ_W'(1);
        end
    end

endmodule

// File: rtl/xstep_seq.sv
// Memory-mapped STEPS-step sequencer: per-step tone, tempo, loop/one-shot, status, LEDs.
// Latency: writes land at the sel&we edge; reads are combinational in the same cycle.
// No backpressure; the bus is always accepted, data_out is 0 unless reading.
module xstep_seq
    import xstep_seq_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int STEPS   = 8,
    parameter int TEMPO_W = 24,
    parameter int FREQ_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              snd_out,
    output logic [STEPS-1:0]  led_out,
    output logic              step_tick
);

    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    seq_state_t         state_q;
    seq_state_t         state_d;
    logic               loop_q;
    logic               done_q;
    logic               step_tick_q;
    logic [TEMPO_W-1:0] tempo_q;
    logic [TEMPO_W-1:0] tempo_cnt_q;
    logic [TEMPO_W-1:0] tempo_reload;
    logic [STEPS-1:0]   mask_q;
    logic [FREQ_W-1:0]  freq_q [STEPS];
    logic [STEP_W-1:0]  step_q;

    logic               wr_en;
    logic               rd_en;
    logic               ctrl_wr;
    logic               tempo_wr;
    logic               mask_wr;
    logic               status_rd;
    logic               freq_hit;
    logic [ADDR_W-1:0]  freq_idx;
    logic               run_bit;
    logic               clr_bit;
    logic               busy;
    logic               start;
    logic               stop;
    logic               adv;
    logic               last_step;
    logic               one_shot_end;
    logic               tone_en;
    logic [DATA_W-1:0]  rd_dat;

    assign wr_en     = sel & we;
    assign rd_en     = sel & ~we;
    assign ctrl_wr   = wr_en && (addr == ADDR_W'(SEQ_CTRL));
    assign tempo_wr  = wr_en && (addr == ADDR_W'(SEQ_TEMPO));
    assign mask_wr   = wr_en && (addr == ADDR_W'(SEQ_MASK));
    assign status_rd = rd_en && (addr == ADDR_W'(SEQ_STATUS));
    assign freq_idx  = addr - ADDR_W'(SEQ_FREQ0);
    assign freq_hit  = (addr >= ADDR_W'(SEQ_FREQ0)) && (freq_idx < ADDR_W'(STEPS));

    assign run_bit = data_in[CTRL_RUN];
    assign clr_bit = data_in[CTRL_CLR];

    // A RUN=1 write while already playing is not a start: the tempo phase is kept
    assign start        = ctrl_wr && run_bit && (state_q == ST_IDLE);
    assign stop         = ctrl_wr && !run_bit && (state_q == ST_PLAY);
    assign adv          = (state_q == ST_PLAY) && (tempo_cnt_q == '0) && !stop;
    assign last_step    = (step_q == LAST_STEP);
    assign one_shot_end = adv && last_step && !loop_q;

    // TEMPO=0 behaves as TEMPO=1: reload 0 so every cycle advances
    assign tempo_reload = (tempo_q == '0) ? '0 : tempo_q - TEMPO_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_PLAY;
            ST_PLAY: if (stop || one_shot_end) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == ST_PLAY);
        led_out = mask_q;
        if (busy) begin
            led_out = STEPS'(1) << step_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tempo_q <= '0;
            mask_q  <= '0;
            loop_q  <= 1'b0;
            for (int i = 0; i < STEPS; i++) begin
                freq_q[i] <= '0;
            end
        end else begin
            if (tempo_wr) tempo_q <= data_in[TEMPO_W-1:0];
            if (mask_wr)  mask_q  <= data_in[STEPS-1:0];
            if (ctrl_wr)  loop_q  <= data_in[CTRL_LOOP];
            for (int i = 0; i < STEPS; i++) begin
                if (wr_en && freq_hit && (freq_idx == ADDR_W'(i))) begin
                    freq_q[i] <= data_in[FREQ_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tempo_cnt_q <= '0;
            step_q      <= '0;
            done_q      <= 1'b0;
            step_tick_q <= 1'b0;
        end else begin
            step_tick_q <= adv;

            if (start || adv) begin
                tempo_cnt_q <= tempo_reload;
            end else if (busy && (tempo_cnt_q != '0)) begin
                tempo_cnt_q <= tempo_cnt_q - TEMPO_W'(1);
            end

            if (ctrl_wr && clr_bit) begin
                step_q <= '0;
            end else if (adv && !one_shot_end) begin
                step_q <= last_step ? '0 : step_q + STEP_W'(1);
            end

            // Setting DONE outranks a concurrent STATUS read so the event is never lost
            if (one_shot_end) begin
                done_q <= 1'b1;
            end else if ((ctrl_wr && clr_bit) || status_rd) begin
                done_q <= 1'b0;
            end
        end
    end

    assign step_tick = step_tick_q;
    assign tone_en   = busy && mask_q[step_q] && (freq_q[step_q] != '0);

    xstep_tone #(
        .FREQ_W      (FREQ_W)
    ) u_tone (
        .clk         (clk),
        .rst         (rst),
        .en          (tone_en),
        .restart     (start | adv),
        .half_period (freq_q[step_q]),
        .snd_out     (snd_out)
    );

    always_comb begin
        rd_dat = '0;
        if (addr == ADDR_W'(SEQ_TEMPO)) begin
            rd_dat = DATA_W'(tempo_q);
        end else if (addr == ADDR_W'(SEQ_STATUS)) begin
            rd_dat[STAT_BUSY]            = busy;
            rd_dat[STAT_DONE]            = done_q;
            rd_dat[STAT_STEP +: STEP_W]  = step_q;
        end else if (addr == ADDR_W'(SEQ_MASK)) begin
            rd_dat = DATA_W'(mask_q);
        end else if (freq_hit) begin
            for (int i = 0; i < STEPS; i++) begin
                if (freq_idx == ADDR_W'(i)) rd_dat = DATA_W'(freq_q[i]);
            end
        end
        data_out = rd_en ? rd_dat : '0;
    end

endmodule

// File: tb/tb_xstep_seq.sv
// Directed bench for xstep_seq: reset, tempo walk, tone, one-shot/DONE, tempo 0, async reset.
module tb_xstep_seq;
    import xstep_seq_pkg::*;

    localparam logic [3:0] A_CTRL   = 4'(SEQ_CTRL);
    localparam logic [3:0] A_TEMPO  = 4'(SEQ_TEMPO);
    localparam logic [3:0] A_STATUS = 4'(SEQ_STATUS);
    localparam logic [3:0] A_MASK   = 4'(SEQ_MASK);
    localparam logic [3:0] A_FREQ0  = 4'(SEQ_FREQ0);

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        sel     = 1'b0;
    logic        we      = 1'b0;
    logic [3:0]  addr    = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        snd_out;
    logic [7:0]  led_out;
    logic        step_tick;

    int test_cnt = 0;
    int fail_cnt = 0;
    logic [31:0] rv;

    xstep_seq #(
        .DATA_W   (32),
        .ADDR_W   (4),
        .STEPS    (8),
        .TEMPO_W  (24),
        .FREQ_W   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .we        (we),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .snd_out   (snd_out),
        .led_out   (led_out),
        .step_tick (step_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = a; data_in = d;
        #1 check("wr_dout", data_out, 32'h0);
        @(posedge clk);
        #1;
        sel = 1'b0; we = 1'b0; data_in = '0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b0; addr = a;
        #1 d = data_out;
        @(posedge clk);
        #1;
        sel = 1'b0;
    endtask

    initial begin
        #22 rst = 1'b1;

        // reset state, unmapped write ignored
        check("rst_led", 32'(led_out), 32'h0);
        check("rst_snd", 32'(snd_out), 32'h0);
        check("rst_tick", 32'(step_tick), 32'h0);
        bus_write(4'd15, 32'hFFFF_FFFF);
        bus_write(4'd12, 32'hFFFF_FFFF);
        for (int a = 0; a < 16; a++) begin
            bus_read(4'(a), rv);
            check($sformatf("rst_reg%0d", a), rv, 32'h0);
        end

        // tempo 4, loop: tick every 4 cycles, one-hot walk with wrap
        bus_write(A_TEMPO, 32'd4);
        bus_write(A_MASK, 32'hFF);
        bus_read(A_TEMPO, rv);
        check("tempo_rd", rv, 32'd4);
        bus_read(A_MASK, rv);
        check("mask_rd", rv, 32'hFF);
        bus_write(A_CTRL, 32'h7);
        for (int c = 1; c <= 32; c++) begin
            @(posedge clk); #1;
            check($sformatf("walk_tick%0d", c), 32'(step_tick), 32'((c % 4) == 0));
            check($sformatf("walk_led%0d", c), 32'(led_out), 32'(1 << ((c / 4) % 8)));
        end
        bus_write(A_CTRL, 32'h0);
        bus_read(A_STATUS, rv);
        check("stop_status", rv, 32'h0);
        check("idle_led", 32'(led_out), 32'hFF);

        // tone on step 0, half-period 3
        bus_write(A_CTRL, 32'h4);
        bus_write(A_FREQ0, 32'd3);
        bus_write(A_TEMPO, 32'd100);
        bus_write(A_MASK, 32'h01);
        bus_read(A_FREQ0, rv);
        check("freq_rd", rv, 32'd3);
        bus_write(A_CTRL, 32'h1);
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk); #1;
            check($sformatf("tone%0d", c), 32'(snd_out), 32'((c / 3) % 2));
        end
        bus_write(A_MASK, 32'h00);
        repeat (2) @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("mask_off_snd", 32'(snd_out), 32'h0);
        end
        bus_write(A_MASK, 32'h01);
        bus_write(A_FREQ0, 32'd0);
        repeat (2) @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("freq0_snd", 32'(snd_out), 32'h0);
        end
        bus_write(A_CTRL, 32'h0);

        // one-shot, tempo 2: end 16 cycles after RUN, DONE set wins over same-cycle read
        bus_write(A_TEMPO, 32'd2);
        bus_write(A_MASK, 32'hFF);
        bus_write(A_CTRL, 32'h5);
        repeat (15) @(posedge clk);
        #1;
        bus_read(A_STATUS, rv);
        check("os_last_status", rv, 32'h701);
        check("os_end_tick", 32'(step_tick), 32'h1);
        check("os_idle_led", 32'(led_out), 32'hFF);
        bus_read(A_STATUS, rv);
        check("os_done_rd1", rv, 32'h702);
        bus_read(A_STATUS, rv);
        check("os_done_rd2", rv, 32'h700);

        // RUN rewrite mid-play keeps tempo phase; CLR mid-play keeps BUSY
        bus_write(A_TEMPO, 32'd4);
        bus_write(A_CTRL, 32'h7);
        bus_write(A_CTRL, 32'h3);
        repeat (2) @(posedge clk);
        #1;
        check("rerun_notick", 32'(step_tick), 32'h0);
        @(posedge clk); #1;
        check("rerun_tick", 32'(step_tick), 32'h1);
        check("rerun_led", 32'(led_out), 32'h02);
        bus_write(A_CTRL, 32'h7);
        check("clr_led", 32'(led_out), 32'h01);
        bus_read(A_STATUS, rv);
        check("clr_status", rv, 32'h001);

        // tempo 0: advance every cycle
        bus_write(A_CTRL, 32'h4);
        bus_write(A_TEMPO, 32'd0);
        bus_write(A_CTRL, 32'h7);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            check($sformatf("t0_led%0d", c), 32'(led_out), 32'(1 << c));
            check($sformatf("t0_tick%0d", c), 32'(step_tick), 32'h1);
        end
        bus_write(A_CTRL, 32'h0);

        // asynchronous reset mid-tone
        bus_write(A_FREQ0, 32'd2);
        bus_write(A_MASK, 32'h01);
        bus_write(A_TEMPO, 32'd100);
        bus_write(A_CTRL, 32'h5);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_snd", 32'(snd_out), 32'h1);
        check("pre_rst_led", 32'(led_out), 32'h01);
        #2 rst = 1'b0;
        #1;
        check("arst_snd", 32'(snd_out), 32'h0);
        check("arst_led", 32'(led_out), 32'h0);
        check("arst_tick", 32'(step_tick), 32'h0);
        #10 rst = 1'b1;
        for (int a = 0; a < 16; a++) begin
            bus_read(4'(a), rv);
            check($sformatf("arst_reg%0d", a), rv, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
